// File: rtl/alu_pkg.sv
// Shared ALU types and widths.
//   XLEN      : datapath width
//   ALU_OP_W  : width of the op select field
//   SHAMT_W   : width of the shift amount taken from operand 2
//   alu_op_e  : op encoding understood by alu; other codes produce 0
package alu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALU_OP_W = 5;
  localparam int unsigned SHAMT_W  = $clog2(XLEN);

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 5'd0,
    ALU_SLL  = 5'd1,
    ALU_SLT  = 5'd2,
    ALU_SLTU = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SRL  = 5'd5,
    ALU_SRA  = 5'd6,
    ALU_OR   = 5'd7,
    ALU_AND  = 5'd8
  } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu.sv
// Combinational integer ALU.
//   oper1_i  : operand 1
//   oper2_i  : operand 2 (low SHAMT_W bits are the shift amount for shifts)
//   op_i     : op select, alu_op_e encoding; undefined codes give 0
//   result_o : result
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]     oper1_i,
  input  logic [XLEN-1:0]     oper2_i,
  input  logic [ALU_OP_W-1:0] op_i,
  output logic [XLEN-1:0]     result_o
);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = oper2_i[SHAMT_W-1:0];

  // Op decode; op_i is kept as a raw vector so undefined codes are legal
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = oper1_i + oper2_i;
      ALU_SLL:  result_o = oper1_i << shamt;
      ALU_SLT:  result_o = XLEN'($signed(oper1_i) < $signed(oper2_i));
      ALU_SLTU: result_o = XLEN'(oper1_i < oper2_i);
      ALU_XOR:  result_o = oper1_i ^ oper2_i;
      ALU_SRL:  result_o = oper1_i >> shamt;
      ALU_SRA:  result_o = XLEN'($signed(oper1_i) >>> shamt);
      ALU_OR:   result_o = oper1_i | oper2_i;
      ALU_AND:  result_o = oper1_i & oper2_i;
      default:  result_o = '0;
    endcase
  end

endmodule : alu

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between NUM_REQ requesters,
// with a one-entry tagged response register.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   req_valid_i   : per-requester request valid
//   req_ready_o   : per-requester accept, one-hot on the winner or zero
//   req_oper1_i   : per-requester operand 1
//   req_oper2_i   : per-requester operand 2
//   req_op_i      : per-requester op select (alu_op_e encoding)
//   rsp_valid_o   : response register holds a result
//   rsp_id_o      : index of the requester owning the result
//   rsp_result_o  : ALU result
//   rsp_ready_i   : consumer accepts the response
// NUM_REQ is legal in 2..4; ID_W is derived and must not be overridden.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0][XLEN-1:0]     req_oper1_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]     req_oper2_i,
  input  logic [NUM_REQ-1:0][ALU_OP_W-1:0] req_op_i,
  output logic                             rsp_valid_o,
  output logic [ID_W-1:0]                  rsp_id_o,
  output logic [XLEN-1:0]                  rsp_result_o,
  input  logic                             rsp_ready_i
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]     prio_q;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     idx;
  logic                any_valid;
  logic                can_accept;
  logic                grant;
  logic [XLEN-1:0]     alu_oper1;
  logic [XLEN-1:0]     alu_oper2;
  logic [ALU_OP_W-1:0] alu_op;
  logic [XLEN-1:0]     alu_result;

  // Output register is free when empty or draining this cycle
  assign can_accept = !rst_i && (!rsp_valid_o || rsp_ready_i);
  assign grant      = any_valid && can_accept;

  // Search from prio_q upward, wrapping at NUM_REQ; first valid wins
  always_comb begin
    winner    = prio_q;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(prio_q) + i) % NUM_REQ);
      if (!any_valid && req_valid_i[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  // One-hot accept on the winner only when the register can take a result
  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[winner] = 1'b1;
    end
  end

  // Winner's operands feed the shared ALU
  assign alu_oper1 = req_oper1_i[winner];
  assign alu_oper2 = req_oper2_i[winner];
  assign alu_op    = req_op_i[winner];

  alu u_alu (
    .oper1_i  (alu_oper1),
    .oper2_i  (alu_oper2),
    .op_i     (alu_op),
    .result_o (alu_result)
  );

  // Response register and round-robin pointer; id/result hold when drained
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= '0;
      rsp_result_o <= '0;
      prio_q       <= '0;
    end else if (grant) begin
      rsp_valid_o  <= 1'b1;
      rsp_id_o     <= winner;
      rsp_result_o <= alu_result;
      prio_q       <= (winner == LAST_ID) ? '0 : winner + ID_W'(1);
    end else if (rsp_valid_o && rsp_ready_i) begin
      rsp_valid_o  <= 1'b0;
    end
  end

endmodule : alu_arbiter
